ppu_hazard_sequencer: RTL
=========================

# ppu_hazard_sequencer

Pipeline sequencer for the PPU datapath. It carries the 18-bit ID-stage control word from the control unit through the EX, MEM and WB stage registers, and detects load-use hazards. On a hazard it stalls PC and IF/ID and injects a bubble into EX. It also produces the ID-stage operand forwarding selects and counts stall cycles for performance debug.

## Interface
- CTRL_W, 18, width of the control word.
- CNT_W, 16, width of the saturating stall counter.
- LOAD_BIT, 10, position of the Load_Instr bit in the control word.
- RFEN_BIT, 9, position of the RF_Enable bit in the control word.

Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_ctrl  in  CTRL_W  control word from the control unit for the instruction in ID.
- id_dest  in  5  destination register of the instruction in ID.
- id_rs, id_rt  in  5 each  source register numbers in ID.
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads rs / rt.
- pipe_hold  in  1  external freeze (memory busy); holds every stage register.
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  registered control words per stage.
- ex_dest, mem_dest, wb_dest  out  5 each  registered destinations per stage.
- pc_le, ifid_le  out  1 each  load enables for PC and IF/ID.
- fwd_a_sel, fwd_b_sel  out  2 each  operand source for rs / rt: 00 register file, 01 EX, 10 MEM, 11 WB.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- **Producer rule:** stage S is a producer when S_ctrl[RFEN_BIT]=1 and S_dest≠0.
- **Load-use hazard (lu):** EX is a producer with ex_ctrl[LOAD_BIT]=1, and either of these holds:
  - ex_dest==id_rs and id_uses_rs=1;
  - ex_dest==id_rt and id_uses_rt=1.
- **Stage advance (pipe_hold=0):**
  - wb ← mem;
  - mem ← ex;
  - ex ← (lu ? {0,0} : {id_ctrl,id_dest}).
- **Stage hold (pipe_hold=1):**
  - all three stage registers keep their values;
  - stall_cnt is unchanged;
  - pipe_hold takes priority over lu, so no bubble is inserted while held.
- **Load enables:** pc_le = ifid_le = !reset && !pipe_hold && !lu. This is combinational.
- **Stall counter:** increments by 1 on every clock edge where lu=1 and pipe_hold=0. It saturates at all-ones and never wraps.
- **Forwarding, rs** (rt identical, using id_rt/id_uses_rt → fwd_b_sel). Rules are evaluated in order; the first match wins:
  1. If id_uses_rs=0 or id_rs==0 → 00.
  2. Else if EX is a producer, ex_dest==id_rs and the EX instruction is not a load → 01.
  3. Else if MEM is a producer and mem_dest==id_rs → 10.
  4. Else if WB is a producer and wb_dest==id_rs → 11.
  5. Else → 00.
- A load sitting in EX is never forwarded; lu covers that case. The fwd selects are still computed when lu=1, but the datapath discards them.
- Register 0 is never a forwarding target and never causes a stall.

## Timing
- **Reset** (synchronous; takes effect at the first rising edge with reset=1):
  - ex/mem/wb_ctrl = 0 and ex/mem/wb_dest = 0;
  - stall_cnt = 0;
  - pc_le = ifid_le = 0 while reset is high;
  - fwd selects = 00 after the reset edge, because all stages are empty.
- Reset mid-operation discards every in-flight control word. The first instruction presented after reset deasserts enters EX at the next edge.
- **Latency:** an accepted id_ctrl appears on ex_ctrl 1 cycle later, on mem_ctrl 2 cycles later, and on wb_ctrl 3 cycles later (counting only cycles without pipe_hold).
- **Load-use sequence:** exactly one bubble.
  - Cycle N: lu=1, so le=0, and the bubble enters EX at the edge.
  - Cycle N+1: the load is in MEM, lu=0, and the stalled consumer sees fwd_sel=10.
- **Back-to-back** loads each feeding the next instruction: one bubble per pair, and stall_cnt increments once per bubble.
- **pipe_hold during lu:** le stays 0 and no bubble is inserted. The bubble is inserted at the first edge where pipe_hold=0.
- The fwd selects and lu are purely combinational from the stage registers and ID inputs. There are no extra cycles.

## Test plan
- **Reset:** assert reset for 2 cycles with id_ctrl=18'h3FFFF, RF_Enable set → all stage ctrl/dest are 0, stall_cnt=0, pc_le=0. Release reset → the word reaches wb_ctrl 3 edges later.
- **EX forward:** addu $3 (ctrl with bit9=1, dest=3), then ID with id_rs=3 → fwd_a_sel=01, pc_le=1. The next cycle, with an unrelated instruction in ID, id_rt=3 → fwd_b_sel=10.
- **Load-use:** load to $5 (bits 10 and 9 set), then ID id_rt=5 with uses_rt=1:
  - lu edge → pc_le=0, ex_ctrl=0 next cycle, stall_cnt=1;
  - following cycle → fwd_b_sel=10 and pc_le=1.
- **Register zero:** a producer with dest=0 and ID id_rs=0 → fwd_a_sel=00, no stall. A load to $0 followed by a reader of $0 → no stall.
- **Priority:** EX, MEM and WB all write $7, ID reads $7 → 01. Then with only MEM and WB writing $7 → 10.
- **Hold:** pipe_hold=1 for 3 cycles during a load-use hazard:
  - stage registers frozen, stall_cnt frozen, pc_le=0;
  - release → one bubble, stall_cnt +1;
  - separately, preload stall_cnt to 16'hFFFF and trigger a stall → the count stays at FFFF.

Source files
------------

// File: rtl/ppu_hazard_sequencer.sv
// Purpose : carries the ID control word through EX/MEM/WB, detects load-use hazards,
//           injects one bubble per hazard, produces ID operand forwarding selects.
// Latency : ID->EX 1 cycle, ->MEM 2, ->WB 3 (held cycles excluded); hazard/fwd are combinational.
// Backpressure: pipe_hold freezes every stage and the stall counter; lu drops pc_le/ifid_le.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_ctrl, id_dest            control word / destination of the instruction in ID
//   id_rs, id_rt                source registers read in ID
//   id_uses_rs, id_uses_rt      ID instruction actually reads rs / rt
//   pipe_hold                   external freeze (memory busy)
//   ex_/mem_/wb_ctrl, _dest     registered per-stage control word and destination
//   pc_le, ifid_le              load enables for PC and IF/ID
//   fwd_a_sel, fwd_b_sel        operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   stall_cnt                   saturating count of load-use bubbles
module ppu_hazard_sequencer #(
  parameter int CTRL_W   = 18,
  parameter int CNT_W    = 16,
  parameter int LOAD_BIT = 10,
  parameter int RFEN_BIT = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_dest,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              pipe_hold,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        ex_dest,
  output logic [4:0]        mem_dest,
  output logic [4:0]        wb_dest,
  output logic              pc_le,
  output logic              ifid_le,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        dest;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{ctrl: '0, dest: '0};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  stage_t id_stage;

  logic ex_prod;
  logic mem_prod;
  logic wb_prod;
  logic ex_is_load;
  logic lu;
  logic advance;

  assign id_stage = '{ctrl: id_ctrl, dest: id_dest};

  // A stage only counts as a producer if it writes a real register;
  // $0 writes are architecturally discarded, so they never forward or stall.
  assign ex_prod    = ex_q.ctrl[RFEN_BIT]  && (ex_q.dest  != 5'd0);
  assign mem_prod   = mem_q.ctrl[RFEN_BIT] && (mem_q.dest != 5'd0);
  assign wb_prod    = wb_q.ctrl[RFEN_BIT]  && (wb_q.dest  != 5'd0);
  assign ex_is_load = ex_q.ctrl[LOAD_BIT];

  // Load data is not available until MEM, so a consumer directly behind a
  // load must wait one cycle.
  assign lu = ex_prod && ex_is_load &&
              (((ex_q.dest == id_rs) && id_uses_rs) ||
               ((ex_q.dest == id_rt) && id_uses_rt));

  assign advance = !pipe_hold;

  assign pc_le   = !reset && !pipe_hold && !lu;
  assign ifid_le = !reset && !pipe_hold && !lu;

  // Youngest matching producer wins; a load in EX is skipped because its
  // value does not exist yet (the hazard logic holds the consumer instead).
  function automatic logic [1:0] fwd_pick(
    input logic       uses,
    input logic [4:0] src,
    input logic       ex_ok,
    input logic [4:0] ex_d,
    input logic       mem_ok,
    input logic [4:0] mem_d,
    input logic       wb_ok,
    input logic [4:0] wb_d
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (!uses || (src == 5'd0)) begin
      sel = 2'b00;
    end else if (ex_ok && (ex_d == src)) begin
      sel = 2'b01;
    end else if (mem_ok && (mem_d == src)) begin
      sel = 2'b10;
    end else if (wb_ok && (wb_d == src)) begin
      sel = 2'b11;
    end
    return sel;
  endfunction

  logic ex_fwd_ok;
  assign ex_fwd_ok = ex_prod && !ex_is_load;

  always_comb begin
    fwd_a_sel = fwd_pick(id_uses_rs, id_rs, ex_fwd_ok, ex_q.dest,
                         mem_prod, mem_q.dest, wb_prod, wb_q.dest);
    fwd_b_sel = fwd_pick(id_uses_rt, id_rt, ex_fwd_ok, ex_q.dest,
                         mem_prod, mem_q.dest, wb_prod, wb_q.dest);
  end

  // Stage registers: hold beats hazard, so a bubble is only injected on an
  // edge where the pipe actually moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= STAGE_EMPTY;
      mem_q <= STAGE_EMPTY;
      wb_q  <= STAGE_EMPTY;
    end else if (advance) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= lu ? STAGE_EMPTY : id_stage;
    end
  end

  // One count per injected bubble; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (advance && lu && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign ex_ctrl  = ex_q.ctrl;
  assign mem_ctrl = mem_q.ctrl;
  assign wb_ctrl  = wb_q.ctrl;
  assign ex_dest  = ex_q.dest;
  assign mem_dest = mem_q.dest;
  assign wb_dest  = wb_q.dest;

endmodule
